// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU issue/writeback
//                controller: op-codes, FSM state encoding, instruction field
//                positions, data width and register index width.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int c_dw    = 8;    // datapath width, matches the ALU
    localparam int c_nregs = 8;    // register file depth
    localparam int c_riw   = 3;    // register index width = log2(c_nregs)
    localparam int c_iw    = 16;   // instruction width

    // LI flag and LI-format fields
    localparam int c_li_bit    = 15;
    localparam int c_li_rd_msb = 14;
    localparam int c_li_rd_lsb = 12;
    localparam int c_imm_msb   = 7;
    localparam int c_imm_lsb   = 0;

    // ALU-format fields
    localparam int c_op_msb  = 14;
    localparam int c_op_lsb  = 12;
    localparam int c_rd_msb  = 11;
    localparam int c_rd_lsb  = 9;
    localparam int c_rs1_msb = 8;
    localparam int c_rs1_lsb = 6;
    localparam int c_rs2_msb = 5;
    localparam int c_rs2_lsb = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_EQL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_t;

    // True when the instruction word is a load-immediate
    function automatic logic f_is_li(input logic [c_iw-1:0] instr);
        return instr[c_li_bit];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_if
//  Description : Instruction handshake, ALU drive/capture, writeback and debug
//                read signals of the ALU controller. The slave modport is the
//                controller's view, master is the surrounding system's view.
//                zero_flag exists only when ALU_CTRL_ZFLAG_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_ctrl_if import alu_pkg::*; ();

    logic [c_iw-1:0]  instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [c_dw-1:0]  alu_a;
    logic [c_dw-1:0]  alu_b;
    logic [2:0]       alu_op;
    logic [c_dw-1:0]  alu_result;
    logic             wb_valid;
    logic [c_riw-1:0] wb_rd;
    logic [c_dw-1:0]  wb_data;
    logic [c_riw-1:0] dbg_addr;
    logic [c_dw-1:0]  dbg_data;
`ifdef ALU_CTRL_ZFLAG_EN
    logic             zero_flag;
`endif

    modport slave (
`ifdef ALU_CTRL_ZFLAG_EN
        output zero_flag,
`endif
        input  instr, instr_valid, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op,
        output wb_valid, wb_rd, wb_data, dbg_data
    );

    modport master (
`ifdef ALU_CTRL_ZFLAG_EN
        input  zero_flag,
`endif
        output instr, instr_valid, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op,
        input  wb_valid, wb_rd, wb_data, dbg_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : NREGS x DW register file, two operand read ports plus a debug
//                read port (all combinational), one synchronous write port.
//                Entry 0 is never written so it always reads zero.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_wa,
    input  wire logic [DW-1:0] i_wd,
    input  wire logic [AW-1:0] i_ra1,
    input  wire logic [AW-1:0] i_ra2,
    input  wire logic [AW-1:0] i_ra3,
    output logic      [DW-1:0] o_rd1,
    output logic      [DW-1:0] o_rd2,
    output logic      [DW-1:0] o_rd3
);

    logic [DW-1:0] r_mem [NREGS];

    // Clear on reset; otherwise write, dropping any write aimed at entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = r_mem[i_ra1];
    assign o_rd2 = r_mem[i_ra2];
    assign o_rd3 = r_mem[i_ra3];

endmodule
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl
//  Description : Multi-cycle issue/writeback controller for the external 8-bit
//                ALU. Accepts one 16-bit instruction per 4 cycles
//                (IDLE -> READ -> EXEC -> WB), drives registered ALU operands,
//                captures the result and writes it to the register file.
//                Optional macro ALU_CTRL_ZFLAG_EN adds a zero_flag output set
//                from the result of each ALU (non-LI) writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl import alu_pkg::*; #(
    parameter int NREGS = c_nregs,
    parameter int DW    = c_dw
) (
    input wire logic   clk,
    input wire logic   rst,
    alu_ctrl_if.slave  bus
);

    state_t             r_state;
    logic [c_iw-1:0]    r_instr;
    logic [DW-1:0]      r_res;
    logic [DW-1:0]      r_alu_a;
    logic [DW-1:0]      r_alu_b;
    alu_op_t            r_alu_op;
    logic               r_wb_valid;
    logic [c_riw-1:0]   r_wb_rd;
`ifdef ALU_CTRL_ZFLAG_EN
    logic               r_zero_flag;
`endif

    logic               w_li;
    logic [c_riw-1:0]   w_rd;
    logic [c_riw-1:0]   w_rs1;
    logic [c_riw-1:0]   w_rs2;
    logic [DW-1:0]      w_rd1;
    logic [DW-1:0]      w_rd2;
    logic [DW-1:0]      w_res_next;
    logic               w_we;
    logic               w_unused_rsvd;

    // Field decode from the latched instruction
    assign w_li       = f_is_li(r_instr);
    assign w_rd       = w_li ? r_instr[c_li_rd_msb:c_li_rd_lsb]
                             : r_instr[c_rd_msb:c_rd_lsb];
    assign w_rs1      = r_instr[c_rs1_msb:c_rs1_lsb];
    assign w_rs2      = r_instr[c_rs2_msb:c_rs2_lsb];
    assign w_res_next = w_li ? r_instr[c_imm_msb:c_imm_lsb] : bus.alu_result;
    assign w_we       = (r_state == S_WB);
    // Reserved ALU-format bits carry no meaning
    assign w_unused_rsvd = ^r_instr[2:0];

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (c_riw)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_we),
        .i_wa  (w_rd),
        .i_wd  (r_res),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .i_ra3 (bus.dbg_addr),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .o_rd3 (bus.dbg_data)
    );

    // Issue FSM: operands are loaded into the ALU drive registers in READ so
    // they are stable for the whole EXEC cycle; the result is captured at the
    // end of EXEC and committed to the register file at the end of WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_res      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= OP_ADD;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
`ifdef ALU_CTRL_ZFLAG_EN
            r_zero_flag <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_instr <= bus.instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_alu_a  <= w_rd1;
                    r_alu_b  <= w_rd2;
                    r_alu_op <= alu_op_t'(r_instr[c_op_msb:c_op_lsb]);
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_res      <= w_res_next;
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= w_rd;
                    r_state    <= S_WB;
                end
                S_WB: begin
                    r_wb_valid <= 1'b0;
`ifdef ALU_CTRL_ZFLAG_EN
                    if (!w_li) begin
                        r_zero_flag <= (r_res == '0);
                    end
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_res;
`ifdef ALU_CTRL_ZFLAG_EN
    assign bus.zero_flag   = r_zero_flag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl
//  Description : Directed self-checking bench for alu_ctrl with a behavioural
//                ALU model attached to the controller's ALU ports.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ctrl_if u_if ();

    alu_ctrl #(.NREGS(8), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference ALU: shifts are by one position, operand b ignored
    always_comb begin
        case (u_if.alu_op)
            3'b000:  u_if.alu_result = u_if.alu_a + u_if.alu_b;
            3'b001:  u_if.alu_result = u_if.alu_a - u_if.alu_b;
            3'b010:  u_if.alu_result = {u_if.alu_a[6:0], 1'b0};
            3'b011:  u_if.alu_result = {1'b0, u_if.alu_a[7:1]};
            3'b100:  u_if.alu_result = u_if.alu_a & u_if.alu_b;
            3'b101:  u_if.alu_result = u_if.alu_a | u_if.alu_b;
            3'b110:  u_if.alu_result = u_if.alu_a ^ u_if.alu_b;
            default: u_if.alu_result = {7'b0, (u_if.alu_a == u_if.alu_b)};
        endcase
    end

    function automatic logic [15:0] f_li(input logic [2:0] rd, input logic [7:0] imm,
                                         input logic [3:0] junk);
        return {1'b1, rd, junk, imm};
    endfunction

    function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2,
                                          input logic [2:0] rsvd);
        return {1'b0, op, rd, rs1, rs2, rsvd};
    endfunction

    // Issue one instruction from IDLE; report the writeback seen, the cycle
    // (counted from the accepting edge) in which wb_valid appeared, and how
    // many cycles instr_ready stayed low. Returns at a falling edge in IDLE.
    task automatic issue(input logic [15:0] ins, output logic [7:0] d,
                         output logic [2:0] rd, output int lat, output int low);
        @(negedge clk);
        u_if.instr       = ins;
        u_if.instr_valid = 1'b1;
        @(posedge clk);
        #1 u_if.instr_valid = 1'b0;
        lat = 0; low = 0; d = '0; rd = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (u_if.wb_valid === 1'b1 && lat == 0) begin
                lat = k;
                d   = u_if.wb_data;
                rd  = u_if.wb_rd;
            end
            if (u_if.instr_ready === 1'b1) break;
            low++;
        end
    endtask

    task automatic dbg_read(input logic [2:0] a, output logic [7:0] d);
        u_if.dbg_addr = a;
        #1 d = u_if.dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        u_if.instr       = f_li(3'd1, 8'hFF, 4'h0);
        u_if.instr_valid = 1'b1;
        u_if.dbg_addr    = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (u_if.instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", u_if.instr_ready); end
        checks++; if (u_if.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%b exp=0", u_if.wb_valid); end
        checks++; if ({u_if.alu_a, u_if.alu_b, u_if.alu_op} !== 19'h0) begin failures++; $display("FAIL rst_alu_outs got=%h/%h/%b exp=0", u_if.alu_a, u_if.alu_b, u_if.alu_op); end
        checks++; if ({u_if.wb_rd, u_if.wb_data} !== 11'h0) begin failures++; $display("FAIL rst_wb_outs got=%h/%h exp=0", u_if.wb_rd, u_if.wb_data); end
`ifdef ALU_CTRL_ZFLAG_EN
        checks++; if (u_if.zero_flag !== 1'b0) begin failures++; $display("FAIL rst_zflag got=%b exp=0", u_if.zero_flag); end
`endif
        rst = 1'b0;
        u_if.instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        dbg_read(3'd1, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL rst_wins_r1 got=%h exp=00", v); end
    endtask

    task automatic test_load_add();
        logic [7:0] d, v; logic [2:0] rd; int lat, low;
        issue(f_li(3'd1, 8'h05, 4'hA), d, rd, lat, low);
        checks++; if (d !== 8'h05 || rd !== 3'd1) begin failures++; $display("FAIL li_r1 got=%h@r%0d exp=05@r1", d, rd); end
        issue(f_li(3'd2, 8'h03, 4'h0), d, rd, lat, low);
        checks++; if (d !== 8'h03 || rd !== 3'd2) begin failures++; $display("FAIL li_r2 got=%h@r%0d exp=03@r2", d, rd); end
        issue(f_alu(3'b000, 3'd3, 3'd1, 3'd2, 3'b101), d, rd, lat, low);
        checks++; if (d !== 8'h08 || rd !== 3'd3) begin failures++; $display("FAIL add_r3 got=%h@r%0d exp=08@r3", d, rd); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL wb_latency got=%0d exp=3", lat); end
        checks++; if (low !== 3) begin failures++; $display("FAIL ready_low_cycles got=%0d exp=3", low); end
        dbg_read(3'd3, v);
        checks++; if (v !== 8'h08) begin failures++; $display("FAIL dbg_r3 got=%h exp=08", v); end
    endtask

    task automatic test_arith();
        logic [7:0] d, v; logic [2:0] rd; int lat, low;
        issue(f_alu(3'b001, 3'd4, 3'd2, 3'd1, 3'b000), d, rd, lat, low);
        checks++; if (d !== 8'hFE || rd !== 3'd4) begin failures++; $display("FAIL sub_r4 got=%h@r%0d exp=FE@r4", d, rd); end
        issue(f_li(3'd5, 8'hF0, 4'h0), d, rd, lat, low);
        issue(f_alu(3'b000, 3'd6, 3'd5, 3'd5, 3'b000), d, rd, lat, low);
        checks++; if (d !== 8'hE0 || rd !== 3'd6) begin failures++; $display("FAIL add_wrap_r6 got=%h@r%0d exp=E0@r6", d, rd); end
        dbg_read(3'd6, v);
        checks++; if (v !== 8'hE0) begin failures++; $display("FAIL dbg_r6 got=%h exp=E0", v); end
    endtask

    task automatic test_logic();
        logic [15:0] ins [7];
        logic [7:0]  exp [7];
        logic [7:0]  d, v; logic [2:0] rd; int lat, low;
        ins[0] = f_alu(3'b010, 3'd7, 3'd5, 3'd1, 3'b000); exp[0] = 8'hE0; // SLL r5
        ins[1] = f_alu(3'b011, 3'd7, 3'd5, 3'd2, 3'b000); exp[1] = 8'h78; // SRL r5
        ins[2] = f_alu(3'b111, 3'd7, 3'd6, 3'd6, 3'b000); exp[2] = 8'h01; // EQL r6,r6
        ins[3] = f_alu(3'b111, 3'd7, 3'd1, 3'd2, 3'b000); exp[3] = 8'h00; // EQL r1,r2
        ins[4] = f_alu(3'b100, 3'd7, 3'd5, 3'd6, 3'b000); exp[4] = 8'hE0; // AND
        ins[5] = f_alu(3'b101, 3'd7, 3'd5, 3'd6, 3'b000); exp[5] = 8'hF0; // OR
        ins[6] = f_alu(3'b110, 3'd7, 3'd5, 3'd6, 3'b000); exp[6] = 8'h10; // XOR
        for (int i = 0; i < 7; i++) begin
            issue(ins[i], d, rd, lat, low);
            checks++; if (d !== exp[i] || rd !== 3'd7) begin failures++; $display("FAIL logic_op%0d got=%h@r%0d exp=%h@r7", i, d, rd, exp[i]); end
        end
        checks++; if (u_if.alu_a !== 8'hF0 || u_if.alu_b !== 8'hE0 || u_if.alu_op !== 3'b110) begin
            failures++; $display("FAIL alu_hold got=%h/%h/%b exp=F0/E0/110", u_if.alu_a, u_if.alu_b, u_if.alu_op); end
        dbg_read(3'd7, v);
        checks++; if (v !== 8'h10) begin failures++; $display("FAIL dbg_r7 got=%h exp=10", v); end
    endtask

    task automatic test_r0_and_hold();
        logic [7:0] d, v; logic [2:0] rd; int lat, low; int pulses;
        issue(f_li(3'd0, 8'hAA, 4'hF), d, rd, lat, low);
        checks++; if (d !== 8'hAA || rd !== 3'd0 || lat !== 3) begin failures++; $display("FAIL li_r0_wb got=%h@r%0d lat=%0d exp=AA@r0 lat=3", d, rd, lat); end
        dbg_read(3'd0, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL r0_zero got=%h exp=00", v); end
        // Hold valid over four rising edges starting in IDLE
        @(negedge clk);
        u_if.instr       = f_li(3'd7, 8'h3C, 4'h0);
        u_if.instr_valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            if (k == 3) #1 u_if.instr_valid = 1'b0;
            @(negedge clk);
            if (u_if.wb_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL hold_valid_pulses got=%0d exp=1", pulses); end
        dbg_read(3'd7, v);
        checks++; if (v !== 8'h3C) begin failures++; $display("FAIL hold_valid_r7 got=%h exp=3C", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v; int pulses;
        @(negedge clk);
        u_if.instr       = f_alu(3'b000, 3'd3, 3'd1, 3'd2, 3'b000);
        u_if.instr_valid = 1'b1;
        @(posedge clk);                 // accepted, enters READ
        #1 u_if.instr_valid = 1'b0;
        @(posedge clk);                 // enters EXEC
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (u_if.wb_valid !== 1'b0 || u_if.instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_ctrl got=wb%b/rdy%b exp=wb0/rdy1", u_if.wb_valid, u_if.instr_ready); end
        checks++; if ({u_if.alu_a, u_if.alu_b, u_if.alu_op, u_if.wb_rd, u_if.wb_data} !== 30'h0) begin
            failures++; $display("FAIL midrst_outs got=%h/%h/%b/%h/%h exp=0", u_if.alu_a, u_if.alu_b, u_if.alu_op, u_if.wb_rd, u_if.wb_data); end
        dbg_read(3'd3, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL midrst_r3 got=%h exp=00", v); end
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (u_if.wb_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_no_wb got=%0d exp=0", pulses); end
    endtask

`ifdef ALU_CTRL_ZFLAG_EN
    task automatic test_zflag();
        logic [7:0] d; logic [2:0] rd; int lat, low;
        issue(f_li(3'd1, 8'h05, 4'h0), d, rd, lat, low);
        issue(f_alu(3'b001, 3'd2, 3'd1, 3'd1, 3'b000), d, rd, lat, low);
        checks++; if (u_if.zero_flag !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL zflag_sub got=%b d=%h exp=1 d=00", u_if.zero_flag, d); end
        issue(f_li(3'd3, 8'h00, 4'h0), d, rd, lat, low);
        checks++; if (u_if.zero_flag !== 1'b1) begin failures++; $display("FAIL zflag_li_keep got=%b exp=1", u_if.zero_flag); end
        issue(f_alu(3'b000, 3'd4, 3'd1, 3'd0, 3'b000), d, rd, lat, low);
        checks++; if (u_if.zero_flag !== 1'b0 || d !== 8'h05) begin failures++; $display("FAIL zflag_add got=%b d=%h exp=0 d=05", u_if.zero_flag, d); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        u_if.instr       = '0;
        u_if.instr_valid = 1'b0;
        u_if.dbg_addr    = '0;
        test_reset();
        test_load_add();
        test_arith();
        test_logic();
        test_r0_and_hold();
        test_reset_mid();
`ifdef ALU_CTRL_ZFLAG_EN
        test_zflag();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Multi-cycle issue/writeback controller wrapped around the 8-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and holds an 8x8 register file.
- Drives the ALU operand and op-code inputs, captures the ALU result and writes it back.
- Sits directly upstream of the ALU, which it feeds, and directly downstream of it, which it consumes. The ALU is instantiated next to it, not inside it.

Parameters:
- NREGS, 8, register file depth; fixed power of two; register index width is log2(NREGS)=3.
- DW, 8, data width; must match the ALU.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  16  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  controller can accept an instruction.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_op  out  3  ALU op-code.
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_op).
- wb_valid  out  1  one-cycle pulse when a writeback occurs.
- wb_rd  out  3  destination register of this writeback.
- wb_data  out  8  data written.
- dbg_addr  in  3  debug read index.
- dbg_data  out  8  combinational read of rf[dbg_addr].

Behaviour:
- Instruction format:
  - instr[15]=1 is LI: rd=instr[14:12], imm=instr[7:0]; instr[11:8] are ignored.
  - instr[15]=0 is ALU: op=instr[14:12], rd=instr[11:9], rs1=instr[8:6], rs2=instr[5:3]; instr[2:0] are reserved and ignored.
- Op-codes: ADD 000, SUB 001, SLL 010, SRL 011, AND 100, OR 101, XOR 110, EQL 111.
- FSM states:
  - IDLE: instr_ready=1. A transfer occurs when instr_valid and instr_ready are both high at an edge. On transfer, latch instr and go to READ. No transfer means stay in IDLE.
  - READ: opa<=rf[rs1], opb<=rf[rs2], then go to EXEC. Applies to LI as well; the values are unused.
  - EXEC: alu_a=opa, alu_b=opb, alu_op=op. res<=alu_result (ALU) or res<=imm (LI), then go to WB.
  - WB: rf[rd]<=res unless rd==0. wb_valid=1, wb_rd=rd, wb_data=res. Then go to IDLE.
- instr_ready is high only in IDLE. instr_valid outside IDLE is ignored; no buffering.
- Latency: an instruction accepted at edge N has its rf write visible at edge N+3, with wb_valid high during the cycle after edge N+2. Throughput is one instruction per 4 cycles.
- r0 reads 0 always. A write to r0 is dropped, but wb_valid still pulses with wb_rd=0 and wb_data=res.
- Back-to-back dependency (rd of instruction k equals rs of instruction k+1) needs no hazard logic: the write completes before the next READ.
- alu_a, alu_b and alu_op are registered outputs. They hold their last EXEC values outside EXEC; ALU outputs outside EXEC are don't-care.
- Arithmetic is the ALU's; the controller does no width extension. Results are 8-bit, wrap-around is defined by the ALU, and SLL/SRL ignore alu_b.
- Reset (including mid-instruction): state=IDLE, all rf=0, opa/opb/res=0, alu_a=0, alu_b=0, alu_op=000, wb_valid=0, wb_rd=0, wb_data=0. Any in-flight instruction is discarded and no writeback occurs. If rst and instr_valid are high together, reset wins.
- dbg_data reflects a write from the edge after the WB cycle.

Optional Feature:
- Macro: ALU_CTRL_ZFLAG_EN.
- Defined: adds output port zero_flag (1 bit, reset 0).
  - Updated in WB as zero_flag<=(res==0) for ALU instructions only.
  - LI instructions leave it unchanged.
  - Holds its value between writebacks.
- Undefined: the port and its logic are absent; no other behaviour changes.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants ADD..EQL;
  - FSM state encoding IDLE/READ/EXEC/WB (2-bit);
  - instruction field bit positions;
  - the LI flag bit position;
  - DW and register index width.
- One natural sub-module, alu_regfile:
  - NREGS x DW;
  - two combinational read ports plus the debug port (three reads in total);
  - one synchronous write port with r0 write suppression;
  - synchronous reset clears all entries.
- FSM and handshake stay in alu_ctrl.

Test Plan:
- Reset then LI r1=0x05, LI r2=0x03, ADD r3=r1+r2 → wb_data=0x08 on the third wb_valid pulse. dbg_addr=3 reads 0x08. Each instruction spans 4 cycles (instr_ready low for 3).
- With r1=0x05 and r2=0x03, run SUB r4=r2-r1 → 0xFE. Load r5=0xF0 via LI, then ADD r6=r5+r5 → 0xE0 (carry dropped).
- With r1=0x05, r2=0x03, r5=0xF0, r6=0xE0:
  - SLL r7=r5 → 0xE0;
  - SRL r7=r5 → 0x78;
  - EQL r7 with rs1=r6, rs2=r6 → 0x01;
  - EQL r7 with rs1=r1, rs2=r2 → 0x00;
  - AND/OR/XOR of 0xF0,0xE0 → 0xE0 / 0xF0 / 0x10.
- LI r0=0xAA → wb_valid=1, wb_rd=0, wb_data=0xAA, and dbg_addr=0 still reads 0x00. Hold instr_valid high for 4 cycles → exactly one instruction accepted.
- Assert rst during EXEC of ADD r3 → no wb_valid, r3=0, all outputs at reset values, instr_ready=1 the cycle after.
- With ALU_CTRL_ZFLAG_EN defined:
  - LI r1=0x05, then SUB r2=r1-r1 → zero_flag=1;
  - then LI r3=0x00 → zero_flag stays 1;
  - then ADD r4=r1+r0 → zero_flag=0.
